// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: core-wide result widths and the CDB broadcast packet shared with the issuer
package cdb_arbiter_pkg;
  localparam int CDB_VAL_W = 8;
  localparam int CDB_TAG_W = 4;
  localparam int CDB_ROB_W = 8;
  typedef struct packed {
    logic [CDB_VAL_W-1:0] val;
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_ROB_W-1:0] robid;
  } cdb_pkt_t;
  localparam int CDB_PKT_W = $bits(cdb_pkt_t);
endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// result_fifo: per-FU result buffer with simultaneous push/pop and a whole-buffer flush
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int W = cdb_arbiter_pkg::CDB_PKT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = r_cnt == CW'(DEPTH);
  assign empty = r_cnt == '0;
  assign w_push = push && !full && !flush;
  assign w_pop = pop && !empty && !flush;
  assign dout = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= inc(r_wr);
      if (w_pop) r_rd <= inc(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= din;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers FU results and broadcasts one per cycle on the CDB, round-robin from rr_ptr
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FU_COUNT = 8,
  parameter int BUF_DEPTH = 2,
  parameter int VAL_W = CDB_VAL_W,
  parameter int TAG_W = CDB_TAG_W,
  parameter int ROB_W = CDB_ROB_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [FU_COUNT-1:0]       fu_valid,
  output logic [FU_COUNT-1:0]       fu_ready,
  input  logic [FU_COUNT*VAL_W-1:0] fu_vals,
  input  logic [FU_COUNT*TAG_W-1:0] fu_tags,
  input  logic [FU_COUNT*ROB_W-1:0] fu_robids,
  output logic                      cdbtransmit,
  output logic [VAL_W-1:0]          cdbval,
  output logic [TAG_W-1:0]          cdbid,
  output logic [ROB_W-1:0]          cdbrobid
);
  localparam int PKT_W = VAL_W + TAG_W + ROB_W;
  localparam int PW = FU_COUNT > 1 ? $clog2(FU_COUNT) : 1;
  logic [PW-1:0] r_rr, w_win;
  logic w_any, w_fire;
  int w_idx;
  logic [FU_COUNT-1:0] w_full, w_empty, w_pop;
  logic [PKT_W-1:0] w_head [FU_COUNT];
  for (genvar i = 0; i < FU_COUNT; i++) begin : g_fu
    result_fifo #(.DEPTH(BUF_DEPTH), .W(PKT_W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .push(fu_valid[i]),
      .pop(w_pop[i]),
      .din({fu_vals[i*VAL_W +: VAL_W], fu_tags[i*TAG_W +: TAG_W], fu_robids[i*ROB_W +: ROB_W]}),
      .dout(w_head[i]),
      .full(w_full[i]),
      .empty(w_empty[i])
    );
  end
  assign fu_ready = ~w_full;
  // Scan backwards so the last hit is the first non-empty FIFO at or after rr_ptr.
  always_comb begin
    w_any = 1'b0;
    w_win = r_rr;
    w_idx = 0;
    for (int k = FU_COUNT - 1; k >= 0; k--) begin
      w_idx = int'(r_rr) + k;
      w_idx = w_idx >= FU_COUNT ? w_idx - FU_COUNT : w_idx;
      if (!w_empty[PW'(w_idx)]) begin
        w_any = 1'b1;
        w_win = PW'(w_idx);
      end
    end
  end
  assign w_fire = w_any && !flush;
  assign w_pop = w_fire ? FU_COUNT'(1) << w_win : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      cdbtransmit <= 1'b0;
      {cdbval, cdbid, cdbrobid} <= '0;
      r_rr <= '0;
    end else begin
      cdbtransmit <= w_fire;
      if (w_fire) begin
        {cdbval, cdbid, cdbrobid} <= w_head[w_win];
        r_rr <= w_win == PW'(FU_COUNT - 1) ? '0 : w_win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed stimulus checked against a queue-based arbiter model
module tb_cdb_arbiter;
  localparam int N = 8, D = 2, VW = 8, TW = 4, RW = 8, PW = VW + TW + RW;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [N-1:0] fu_valid = '0, fu_ready;
  logic [N*VW-1:0] fu_vals = '0;
  logic [N*TW-1:0] fu_tags = '0;
  logic [N*RW-1:0] fu_robids = '0;
  logic cdbtransmit;
  logic [VW-1:0] cdbval;
  logic [TW-1:0] cdbid;
  logic [RW-1:0] cdbrobid;
  cdb_arbiter #(.FU_COUNT(N), .BUF_DEPTH(D), .VAL_W(VW), .TAG_W(TW), .ROB_W(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_vals(fu_vals), .fu_tags(fu_tags), .fu_robids(fu_robids),
    .cdbtransmit(cdbtransmit), .cdbval(cdbval), .cdbid(cdbid), .cdbrobid(cdbrobid)
  );
  always #5 clk = ~clk;
  logic [PW-1:0] mq [N][$];
  logic [PW-1:0] exq [$];
  logic [2:0] hist [$];
  logic [N-1:0] acc = '0;
  logic [PW-1:0] last = '0;
  bit exp_tx = 1'b0, started = 1'b0;
  int rr = 0;
  int rem [N];
  int pass_n = 0, total_n = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  // Reference model: each FU is a bounded queue; one pop per edge from the first non-empty queue after rr.
  always @(posedge clk) begin
    logic [N-1:0] rdy;
    int w;
    acc = '0;
    for (int i = 0; i < N; i++) rdy[i] = mq[i].size() < D;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exq.delete();
      rr = 0;
      exp_tx = 1'b0;
      last = '0;
      started = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_tx = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && mq[(rr + k) % N].size() > 0) w = (rr + k) % N;
      exp_tx = w >= 0;
      if (w >= 0) begin
        exq.push_back(mq[w].pop_front());
        rr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (fu_valid[i] && rdy[i]) begin
          mq[i].push_back({fu_vals[i*VW +: VW], fu_tags[i*TW +: TW], fu_robids[i*RW +: RW]});
          acc[i] = 1'b1;
        end
    end
  end
  always @(negedge clk) if (started) begin
    logic [N-1:0] mr;
    for (int i = 0; i < N; i++) mr[i] = mq[i].size() < D;
    chk("fu_ready", fu_ready, mr);
    chk("cdbtransmit", cdbtransmit, exp_tx);
    if (exp_tx && exq.size() > 0) last = exq.pop_front();
    if (cdbtransmit) hist.push_back(cdbrobid[RW-1 -: 3]);
    chk("cdb_packet", {cdbval, cdbid, cdbrobid}, last);
  end
  task automatic new_pkt(input int i);
    fu_vals[i*VW +: VW] = VW'($urandom);
    fu_tags[i*TW +: TW] = TW'($urandom);
    fu_robids[i*RW +: RW] = {3'(i), 5'($urandom)};
  endtask
  task automatic load(input int i, input logic [VW-1:0] v, input logic [TW-1:0] t, input logic [RW-1:0] r);
    fu_vals[i*VW +: VW] = v;
    fu_tags[i*TW +: TW] = t;
    fu_robids[i*RW +: RW] = r;
    rem[i] = 1;
  endtask
  task automatic step();
    for (int i = 0; i < N; i++) fu_valid[i] = rem[i] > 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        rem[i]--;
        new_pkt(i);
      end
    for (int i = 0; i < N; i++) fu_valid[i] = rem[i] > 0;
  endtask
  initial begin
    logic [N-1:0] seen;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (3) step();
    rst = 1'b0;
    load(2, 8'hAA, 4'h3, 8'h05);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    foreach (rem[i]) if (i == 0 || i == 3 || i == 7) begin
      new_pkt(i);
      rem[i] = 1;
    end
    repeat (5) step();
    load(1, 8'h11, 4'h1, 8'h01);
    load(0, 8'h22, 4'h2, 8'h02);
    repeat (4) step();
    rem[0] = 1000;
    rem[1] = 3;
    repeat (12) step();
    rem[0] = 0;
    repeat (4) step();
    for (int i = 0; i < N; i++) rem[i] = 1000;
    repeat (40) step();
    seen = '0;
    for (int k = 0; k < N; k++) seen[hist[hist.size() - 1 - k]] = 1'b1;
    chk("fairness_window", seen, {N{1'b1}});
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (10) step();
    for (int i = 0; i < 4; i++) begin
      new_pkt(i);
      rem[i] = 1;
    end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) step();
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 4);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    repeat (400) begin
      for (int i = 0; i < N; i++) if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 3);
      flush = $urandom_range(0, 39) == 0;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    flush = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (12) step();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
